pipe_adder: RTL

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder.sv | 108 ++++++++++
 1 files changed

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - segmented carry-chain adder/subtractor, one carry segment per pipeline stage
// Each stage adds one operand slice and forwards the carry plus the not-yet-added upper slices.
module pipe_adder #(
  parameter int WIDTH = 8,
  parameter int SEG   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             overflow
);
  localparam int S = WIDTH / SEG;

  logic en;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < SEG; k++) begin : stg
    // UW: bits of each operand not yet consumed when reaching stage k
    localparam int UW = WIDTH - k * S;

    logic              v_in;
    logic              c_in;
    logic              sub_in;
    logic [UW-1:0]     a_up;
    logic [UW-1:0]     bx_up;
    logic [S:0]        seg_sum;
    logic [(k+1)*S-1:0] sum_nx;
    logic              vld_q;
    logic [(k+1)*S-1:0] sum_q;

    if (k == 0) begin : src
      assign v_in   = in_valid;
      assign c_in   = sub;
      assign sub_in = sub;
      assign a_up   = a;
      assign bx_up  = b ^ {WIDTH{sub}};
      assign sum_nx = seg_sum[S-1:0];
    end else begin : src
      assign v_in   = stg[k-1].vld_q;
      assign c_in   = stg[k-1].mid.cy_q;
      assign sub_in = stg[k-1].mid.sub_q;
      assign a_up   = stg[k-1].mid.a_q;
      assign bx_up  = stg[k-1].mid.bx_q;
      assign sum_nx = {seg_sum[S-1:0], stg[k-1].sum_q};
    end

    assign seg_sum = {1'b0, a_up[S-1:0]} + {1'b0, bx_up[S-1:0]} + {{S{1'b0}}, c_in};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        sum_q <= '0;
      end else if (en) begin
        vld_q <= v_in;
        sum_q <= sum_nx;
      end
    end

    if (k < SEG - 1) begin : mid
      logic            cy_q;
      logic            sub_q;
      logic [UW-S-1:0] a_q;
      logic [UW-S-1:0] bx_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cy_q  <= 1'b0;
          sub_q <= 1'b0;
          a_q   <= '0;
          bx_q  <= '0;
        end else if (en) begin
          cy_q  <= seg_sum[S];
          sub_q <= sub_in;
          a_q   <= a_up[UW-1:S];
          bx_q  <= bx_up[UW-1:S];
        end
      end
    end else begin : last
      logic hi_q;
      logic ov_q;

      // Final carry is inverted into a borrow for subtraction
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hi_q <= 1'b0;
          ov_q <= 1'b0;
        end else if (en) begin
          hi_q <= seg_sum[S] ^ sub_in;
          ov_q <= (a_up[S-1] == bx_up[S-1]) && (seg_sum[S-1] != a_up[S-1]);
        end
      end
    end
  end

  assign out_valid = stg[SEG-1].vld_q;
  assign result    = {stg[SEG-1].last.hi_q, stg[SEG-1].sum_q};
  assign overflow  = stg[SEG-1].last.ov_q;

endmodule
